i2c_slave_rx: RTL and testbench
===============================

I2C_SLAVE_RX -- requirements
Module: i2c_slave_rx

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, is the 7-bit device address this receiver answers.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  single-cycle START/repeated-START event from the transition detector.
REQ-005 stop  input  1  single-cycle STOP event from the transition detector.
REQ-006 scl_rise  input  1  single-cycle SCL low-to-high event.
REQ-007 scl_fall  input  1  single-cycle SCL high-to-low event.
REQ-008 sda  input  1  registered SDA level, aligned with scl_rise.
REQ-009 sda_oe  output  1  1 = pull SDA low (ACK); 0 = release SDA.
REQ-010 rx_data  output  8  received data byte, valid while rx_valid = 1.
REQ-011 rx_valid  output  1  holding register full.
REQ-012 rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
REQ-013 addressed  output  1  high from own-address ACK until the next START or STOP.
REQ-014 overflow  output  1  sticky flag: a data byte arrived while the holding register was full.

Function
REQ-015 States SHALL be IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK and IGNORE.
REQ-016 start SHALL, from any state, clear the bit counter and go to ADDR; addressed SHALL be cleared.
REQ-017 stop SHALL, from any state, go to IDLE with sda_oe = 0 and addressed = 0.
REQ-018 If start and stop occur in the same cycle, stop SHALL win.
REQ-019 In ADDR and DATA, each scl_rise SHALL shift sda into shift[0], MSB first, and increment a 3-bit counter.
REQ-020 The 8th scl_rise in ADDR SHALL compare shift[7:1] with SLAVE_ADDR.
- Match with R/W = 0: next state is ADDR_ACK.
- Otherwise, including any read request: next state is IGNORE.
REQ-021 In ADDR_ACK, sda_oe SHALL assert on the first scl_fall, deassert on the next scl_fall, and then enter DATA; addressed SHALL set at assertion.
REQ-022 The 8th scl_rise in DATA SHALL handle the byte as follows.
- Holding register empty, or emptied in the same cycle: load rx_data, set rx_valid the next cycle, enter DATA_ACK with ACK.
- Otherwise: discard the byte, set overflow, enter DATA_ACK with NACK (sda_oe stays 0).
REQ-023 DATA_ACK SHALL drive the ACK/NACK exactly as ADDR_ACK does, then return to DATA with the counter at 0.
REQ-024 IGNORE SHALL keep sda_oe = 0 and leave only on start or stop.
REQ-025 rx_valid SHALL clear in the cycle after an rx_valid & rx_ready handshake; rx_data SHALL remain stable while rx_valid = 1.
REQ-026 scl_rise/scl_fall in IDLE SHALL be ignored.
REQ-027 A start arriving mid-byte or mid-ACK SHALL release sda_oe in the same cycle as the state change.
REQ-028 overflow SHALL clear only on reset.

Reset
REQ-029 While rst is high, the block SHALL hold the following reset values.
- State: IDLE.
- Counter and shift register: 0.
- sda_oe, rx_valid, addressed, overflow: 0.
- rx_data: 8'h00.
REQ-030 Reset deassertion mid-transfer SHALL leave the block in IDLE until the next start.

Configuration
REQ-031 Macro I2C_GENCALL_EN: when defined, address 7'h00 with R/W = 0 SHALL also be ACKed and handled like an own-address match; when undefined, 7'h00 goes to IGNORE.

Structure
REQ-032 The state encoding, the ACK bit position (9) and the general-call address constant SHALL live in the shared i2c definitions package.
REQ-033 A sub-module i2c_shift8, holding the shift register and bit counter with a done pulse, SHALL be instantiated once; all other logic is flat.

Verification
REQ-034 Write address 0x50, data 0xA5, rx_ready = 1: ACK on bits 9 and 18, rx_data = 0xA5, a single rx_valid pulse, addressed = 1.
REQ-035 Address 0x51 write: no ACK, state IGNORE, no rx_valid; a following stop returns the block to IDLE.
REQ-036 Address 0x50 with R/W = 1: NACK, IGNORE.
REQ-037 rx_ready = 0, two bytes 0x11 and 0x22: 0x11 held and ACKed, 0x22 NACKed, overflow = 1.
REQ-038 Repeated start after 4 data bits, then address 0x50 and data 0x3C: rx_data = 0x3C and no partial byte is delivered.
REQ-039 Address 0x00 write: ACK only when I2C_GENCALL_EN is defined; rst asserted mid-ACK releases sda_oe immediately.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding, ACK bit position and
// the general-call address.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_DATA     = 3'd3,
    ST_DATA_ACK = 3'd4,
    ST_IGNORE   = 3'd5
  } state_e;

  // The acknowledge occupies the 9th SCL period of every transfer.
  localparam int ACK_BIT_POS = 9;

  // Bit-counter value seen on the 8th (last) data bit, just before the ACK.
  localparam logic [2:0] LAST_BIT_CNT = 3'(ACK_BIT_POS - 2);

  localparam logic [6:0] GENCALL_ADDR = 7'h00;

endpackage

// File: rtl/i2c_shift8.sv
// 8-bit MSB-first shift register with a 3-bit bit counter.
// done pulses combinationally on the 8th shift; byte_nxt is the byte
// including the bit being shifted in that cycle.
module i2c_shift8
  import i2c_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       bit_in,
  output logic [7:0] byte_nxt,
  output logic       done
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;

  // Next shift/count: clear wins over shifting; counter wraps to 0 after 8 bits.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shift_d = {shift_q[6:0], bit_in};
      cnt_d   = cnt_q + 3'd1;
    end
  end

  // Shift register and counter flops.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign byte_nxt = {shift_q[6:0], bit_in};
  assign done     = shift_en & ~clr & (cnt_q == LAST_BIT_CNT);

endmodule

// File: rtl/i2c_slave_rx.sv
// I2C write-only slave receiver with ACK generation and a one-byte
// holding register. Optional macro I2C_GENCALL_EN also accepts the
// general-call address (7'h00, write).
module i2c_slave_rx
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       scl_rise,
  input  logic       scl_fall,
  input  logic       sda,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       addressed,
  output logic       overflow
);

`ifdef I2C_GENCALL_EN
  localparam logic GENCALL_ON = 1'b1;
`else
  localparam logic GENCALL_ON = 1'b0;
`endif

  state_e     state_q, state_d;
  logic       sda_oe_q, sda_oe_d;
  logic       ack_phase_q, ack_phase_d;  // 1 once the ACK has been driven
  logic       nack_q, nack_d;            // current ACK slot is a NACK
  logic       addressed_q, addressed_d;
  logic       rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       overflow_q, overflow_d;

  logic       shift_en, shift_clr, byte_done;
  logic [7:0] byte_nxt;
  logic       addr_match, hold_free;

  // Only ADDR and DATA sample bits; start/stop override any sampling.
  assign shift_en  = scl_rise & ~start & ~stop &
                     ((state_q == ST_ADDR) || (state_q == ST_DATA));
  assign shift_clr = start | stop;

  i2c_shift8 u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (shift_clr),
    .shift_en (shift_en),
    .bit_in   (sda),
    .byte_nxt (byte_nxt),
    .done     (byte_done)
  );

  assign addr_match = ~byte_nxt[0] &
                      ((byte_nxt[7:1] == SLAVE_ADDR) ||
                       (GENCALL_ON && (byte_nxt[7:1] == GENCALL_ADDR)));
  // A byte may be loaded if the register is empty or drained this cycle.
  assign hold_free  = ~rx_valid_q | rx_ready;

  // Next-state, ACK drive and holding-register logic.
  always_comb begin
    // NOTE: every signal gets its default first so no path infers a latch.
    state_d     = state_q;
    sda_oe_d    = sda_oe_q;
    ack_phase_d = ack_phase_q;
    nack_d      = nack_q;
    addressed_d = addressed_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    overflow_d  = overflow_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (stop) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      addressed_d = 1'b0;
    end else if (start) begin
      state_d     = ST_ADDR;
      sda_oe_d    = 1'b0;
      ack_phase_d = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (byte_done) begin
            state_d = addr_match ? ST_ADDR_ACK : ST_IGNORE;
            nack_d  = 1'b0;
          end
        end
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_oe_d    = ~nack_q;
              if (state_q == ST_ADDR_ACK) addressed_d = 1'b1;
            end else begin
              ack_phase_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (byte_done) begin
            state_d = ST_DATA_ACK;
            if (hold_free) begin
              rx_data_d  = byte_nxt;
              rx_valid_d = 1'b1;
              nack_d     = 1'b0;
            end else begin
              overflow_d = 1'b1;
              nack_d     = 1'b1;
            end
          end
        end
        default: ;  // IDLE and IGNORE wait for start/stop
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sda_oe_q    <= 1'b0;
      ack_phase_q <= 1'b0;
      nack_q      <= 1'b0;
      addressed_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sda_oe_q    <= sda_oe_d;
      ack_phase_q <= ack_phase_d;
      nack_q      <= nack_d;
      addressed_q <= addressed_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign addressed = addressed_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed testbench for i2c_slave_rx. Expected ACK on address 7'h00
// follows the I2C_GENCALL_EN macro.
module tb_i2c_slave_rx;
  import i2c_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, stop = 1'b0;
  logic       scl_rise = 1'b0, scl_fall = 1'b0;
  logic       sda = 1'b1;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       addressed;
  logic       overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int valid_cycles = 0;  // running count of cycles with rx_valid high

`ifdef I2C_GENCALL_EN
  localparam logic EXP_GENCALL_ACK = 1'b1;
`else
  localparam logic EXP_GENCALL_ACK = 1'b0;
`endif

  i2c_slave_rx #(.SLAVE_ADDR(7'h50)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda       (sda),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .addressed (addressed),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rx_valid) valid_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling clock edge.
  task automatic do_rise(input logic b);
    sda = b; scl_rise = 1'b1;
    @(negedge clk); scl_rise = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_fall();
    scl_fall = 1'b1;
    @(negedge clk); scl_fall = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      do_rise(b[i]);
      do_fall();
    end
  endtask

  // Samples sda_oe during the ACK slot, then clocks the 9th bit.
  task automatic ack_slot(output logic oe);
    oe = sda_oe;
    do_rise(1'b1);
    do_fall();
  endtask

  task automatic send_start();
    start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
  endtask

  task automatic send_stop();
    stop = 1'b1; @(negedge clk); stop = 1'b0; @(negedge clk);
  endtask

  logic oe;
  int   vc0;

  initial begin
    // Reset values while rst is held
    repeat (3) @(negedge clk);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_rx_valid", 32'(rx_valid), 0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    check("rst_addressed", 32'(addressed), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    // SCL events in IDLE are ignored
    send_bits(8'hA0, 8);
    check("idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("idle_sda_oe", 32'(sda_oe), 0);

    // Address 0x50 write, data 0xA5, consumer always ready
    rx_ready = 1'b1;
    vc0 = valid_cycles;
    send_start();
    send_bits(8'hA0, 8);
    ack_slot(oe);
    check("w50_addr_ack", 32'(oe), 1);
    check("w50_addressed", 32'(addressed), 1);
    check("w50_release", 32'(sda_oe), 0);
    send_bits(8'hA5, 8);
    ack_slot(oe);
    check("w50_data_ack", 32'(oe), 1);
    check("w50_rx_data", 32'(rx_data), 32'hA5);
    check("w50_valid_pulse", 32'(valid_cycles - vc0), 1);
    check("w50_data_state", 32'(dut.state_q), 32'(ST_DATA));
    send_stop();
    check("stop_addressed", 32'(addressed), 0);
    check("stop_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Address 0x51 write: not ours
    vc0 = valid_cycles;
    send_start();
    send_bits(8'hA2, 8);
    ack_slot(oe);
    check("w51_nack", 32'(oe), 0);
    check("w51_ignore", 32'(dut.state_q), 32'(ST_IGNORE));
    send_bits(8'h55, 8);
    ack_slot(oe);
    check("w51_data_nack", 32'(oe), 0);
    check("w51_no_valid", 32'(valid_cycles - vc0), 0);
    send_stop();
    check("w51_stop_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // Address 0x50 read request
    send_start();
    send_bits(8'hA1, 8);
    ack_slot(oe);
    check("r50_nack", 32'(oe), 0);
    check("r50_ignore", 32'(dut.state_q), 32'(ST_IGNORE));
    check("r50_addressed", 32'(addressed), 0);
    send_stop();

    // Overflow: consumer stalled, two bytes
    rx_ready = 1'b0;
    send_start();
    send_bits(8'hA0, 8);
    ack_slot(oe);
    send_bits(8'h11, 8);
    ack_slot(oe);
    check("ovf_first_ack", 32'(oe), 1);
    check("ovf_first_valid", 32'(rx_valid), 1);
    send_bits(8'h22, 8);
    ack_slot(oe);
    check("ovf_second_nack", 32'(oe), 0);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_data_held", 32'(rx_data), 32'h11);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovf_drained", 32'(rx_valid), 0);
    send_stop();
    check("ovf_sticky", 32'(overflow), 1);

    // Repeated start after 4 data bits
    vc0 = valid_cycles;
    send_start();
    send_bits(8'hA0, 8);
    ack_slot(oe);
    send_bits(8'hF0, 4);
    send_start();
    check("rs_state", 32'(dut.state_q), 32'(ST_ADDR));
    check("rs_no_partial", 32'(valid_cycles - vc0), 0);
    send_bits(8'hA0, 8);
    ack_slot(oe);
    check("rs_addr_ack", 32'(oe), 1);
    send_bits(8'h3C, 8);
    ack_slot(oe);
    check("rs_data_ack", 32'(oe), 1);
    check("rs_rx_data", 32'(rx_data), 32'h3C);
    check("rs_one_byte", 32'(valid_cycles - vc0), 1);
    send_stop();

    // General-call address
    send_start();
    send_bits(8'h00, 8);
    ack_slot(oe);
    check("gc_ack", 32'(oe), 32'(EXP_GENCALL_ACK));
    send_stop();

    // Start and stop together: stop wins
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    @(negedge clk);
    check("ss_stop_wins", 32'(dut.state_q), 32'(ST_IDLE));

    // Start mid-ACK releases sda_oe with the state change
    send_start();
    send_bits(8'hA0, 8);
    check("mid_ack_driven", 32'(sda_oe), 1);
    send_start();
    check("mid_ack_start_rel", 32'(sda_oe), 0);

    // Reset asserted mid-ACK releases sda_oe without a clock edge
    send_bits(8'hA0, 8);
    check("rst_ack_driven", 32'(sda_oe), 1);
    rst = 1'b1;
    #1;
    check("rst_ack_release", 32'(sda_oe), 0);
    check("rst_ovf_clear", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_bits(8'hA0, 8);
    check("post_rst_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("post_rst_oe", 32'(sda_oe), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
